// File: rtl/ro_entropy_source.sv
// ro_entropy_source: ring-oscillator entropy source.
// NUM_RINGS rings are sampled through two-flop synchronisers and XOR-combined
// into one raw bit per clock. The raw stream feeds a sticky repetition-count
// health test and is packed into WORD_WIDTH-bit words on a valid/ready port.
// Build option: define RO_VON_NEUMANN_EN to insert a von Neumann debiaser
// between the raw stream and the packer. When it is undefined, every raw bit
// goes straight to the packer.
// ring_out is the documented force point for benches driving the raw stream.
module ro_entropy_source #(
  parameter int NUM_RINGS  = 4,
  parameter int RING_SIZE  = 3,
  parameter int DELAY      = 2,
  parameter int WORD_WIDTH = 8,
  parameter int REP_LIMIT  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  word_ready,
  output logic                  word_valid,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic                  health_fail
);

  localparam int TW = $clog2(DELAY + NUM_RINGS + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam int CW = $clog2(WORD_WIDTH);
  // Stopped ring: NOR stage low, then alternating through the inverters,
  // so the last (even-indexed) stage idles low.
  localparam logic [RING_SIZE-1:0] RING_IDLE = RING_SIZE'({RING_SIZE{2'b10}});

  logic                 ring_stop;
  logic [RING_SIZE-1:0] ring_stage [NUM_RINGS];
  logic [TW-1:0]        ring_tick  [NUM_RINGS];
  logic [NUM_RINGS-1:0] ring_out;

  logic [NUM_RINGS-1:0] sync_q1;
  logic [NUM_RINGS-1:0] sync_q2;
  logic                 raw_bit;
  logic [1:0]           fill_cnt;
  logic                 raw_valid;

  logic [RW-1:0]        rep_cnt;
  logic [RW-1:0]        rep_next;
  logic                 rep_bit;
  logic                 fail_trip;

  logic                 acc_valid;
  logic                 acc_bit;
  logic                 take;
  logic                 xfer;
  logic [CW-1:0]        bit_cnt;

  assign ring_stop = ~enable | reset;

  // Behavioural stand-in for the oscillator fabric: each stage advances once
  // every DELAY+r clocks, so rings run at distinct rates without a zero-delay
  // loop. Stage 0 is NOR(stop, last stage), the rest invert their neighbour.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_RINGS; r++) begin
        ring_stage[r] <= RING_IDLE;
        ring_tick[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_RINGS; r++) begin
        if (ring_stop) begin
          ring_stage[r] <= RING_IDLE;
          ring_tick[r]  <= TW'(DELAY + r - 1);
        end else if (ring_tick[r] == '0) begin
          ring_stage[r] <= ~{ring_stage[r][RING_SIZE-2:0], ring_stage[r][RING_SIZE-1]};
          ring_tick[r]  <= TW'(DELAY + r - 1);
        end else begin
          ring_tick[r]  <= ring_tick[r] - 1'b1;
        end
      end
    end
  end

  // Last-stage tap of every ring.
  always_comb begin
    ring_out = '0;
    for (int r = 0; r < NUM_RINGS; r++) begin
      ring_out[r] = ring_stage[r][RING_SIZE-1];
    end
  end

  // Two-flop synchronisers, then the registered XOR combiner.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      raw_bit <= 1'b0;
    end else begin
      sync_q1 <= ring_out;
      sync_q2 <= sync_q1;
      raw_bit <= ^sync_q2;
    end
  end

  // Pipeline fill down-counter: the three raw bits already in the sync/XOR
  // pipeline when enable rises predate the rings starting and are skipped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fill_cnt <= 2'd3;
    end else if (!enable) begin
      fill_cnt <= 2'd3;
    end else if (fill_cnt != 2'd0) begin
      fill_cnt <= fill_cnt - 2'd1;
    end
  end

  assign raw_valid = enable & (fill_cnt == 2'd0);

  // Repetition count on the raw stream; the trip is flagged on the edge that
  // registers the REP_LIMIT-th identical bit.
  always_comb begin
    rep_next  = rep_cnt;
    fail_trip = 1'b0;
    if (raw_valid && !health_fail) begin
      if (rep_cnt != '0 && raw_bit == rep_bit) begin
        rep_next = (rep_cnt == RW'(REP_LIMIT)) ? rep_cnt : rep_cnt + 1'b1;
      end else begin
        rep_next = RW'(1);
      end
      fail_trip = (rep_next == RW'(REP_LIMIT));
    end
  end

  // Health-test state; health_fail is sticky until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_cnt     <= '0;
      rep_bit     <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (!enable) begin
        rep_cnt <= '0;
        rep_bit <= 1'b0;
      end else if (raw_valid) begin
        rep_cnt <= rep_next;
        rep_bit <= raw_bit;
      end
      if (fail_trip) begin
        health_fail <= 1'b1;
      end
    end
  end

`ifdef RO_VON_NEUMANN_EN
  logic pair_second;
  logic pair_first;

  // Pair tracker: remember the first bit, judge the pair on the second.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pair_second <= 1'b0;
      pair_first  <= 1'b0;
    end else if (!enable) begin
      pair_second <= 1'b0;
      pair_first  <= 1'b0;
    end else if (raw_valid) begin
      pair_second <= ~pair_second;
      if (!pair_second) begin
        pair_first <= raw_bit;
      end
    end
  end

  // 01 yields 0 and 10 yields 1, i.e. the first bit of an unequal pair.
  assign acc_valid = raw_valid & pair_second & (pair_first != raw_bit);
  assign acc_bit   = pair_first;
`else
  assign acc_valid = raw_valid;
  assign acc_bit   = raw_bit;
`endif

  assign xfer = word_valid & word_ready;
  assign take = acc_valid & ~health_fail & ~fail_trip;

  // Word packer and output handshake. While a word waits for the consumer,
  // new bits are dropped; on the transfer edge a fresh bit starts the next word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_valid <= 1'b0;
      word_data  <= '0;
      bit_cnt    <= '0;
    end else if (health_fail || fail_trip) begin
      word_valid <= 1'b0;
    end else begin
      if (xfer) begin
        word_valid <= 1'b0;
        if (take) begin
          word_data <= {word_data[WORD_WIDTH-2:0], acc_bit};
          bit_cnt   <= CW'(1);
        end else begin
          bit_cnt   <= '0;
        end
      end else if (!word_valid && take) begin
        word_data <= {word_data[WORD_WIDTH-2:0], acc_bit};
        if (bit_cnt == CW'(WORD_WIDTH - 1)) begin
          word_valid <= 1'b1;
          bit_cnt    <= '0;
        end else begin
          bit_cnt    <= bit_cnt + 1'b1;
        end
      end
      if (!enable) begin
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ro_entropy_source.sv
// Directed bench for ro_entropy_source: drives the raw stream by forcing
// ring_out (one raw bit per clock, parity of the forced vector = raw bit) and
// checks words, backpressure, enable handling and the health test.
`timescale 1ns/1ps
module tb_ro_entropy_source;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       word_ready;
  logic       word_valid;
  logic [7:0] word_data;
  logic       health_fail;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         pat_idx = 0;
  logic [3:0] ro_drive;

  ro_entropy_source #(
    .NUM_RINGS (4),
    .RING_SIZE (3),
    .DELAY     (2),
    .WORD_WIDTH(8),
    .REP_LIMIT (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .word_ready (word_ready),
    .word_valid (word_valid),
    .word_data  (word_data),
    .health_fail(health_fail)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One raw bit per clock; hold=1 keeps ring_out at one fixed vector (parity 1).
  task automatic drive_ro(input logic b, input logic hold);
    @(negedge clock);
    enable = 1'b1;
    if (hold) begin
      ro_drive = 4'b1011;
    end else begin
      ro_drive = {pat_idx[2:0], b ^ (^pat_idx[2:0])};
      pat_idx++;
    end
    force dut.ring_out = ro_drive;
  endtask

  task automatic send_raw(input logic b);
    drive_ro(b, 1'b0);
  endtask

  // One accepted bit: a 10/01 pair with the debiaser, a single raw bit without.
  task automatic send_bit(input logic b);
`ifdef RO_VON_NEUMANN_EN
    drive_ro(b, 1'b0);
    drive_ro(~b, 1'b0);
`else
    drive_ro(b, 1'b0);
`endif
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  // Let the last bit through the 3-stage pipeline, then drop enable so the
  // filler bits are never consumed. Returns on the negedge enable falls.
  task automatic flush();
    for (int i = 0; i < 3; i++) drive_ro(1'b0, 1'b0);
    @(negedge clock);
    enable = 1'b0;
  endtask

  initial begin
    logic [7:0]  raw8;
    logic [19:0] raw20;
    logic [7:0]  frozen;

    reset      = 1'b1;
    enable     = 1'b0;
    word_ready = 1'b1;
    ro_drive   = 4'h0;
    force dut.ring_out = ro_drive;
    repeat (2) @(negedge clock);
    check("reset_valid", {7'd0, word_valid}, 8'h00);
    check("reset_data", word_data, 8'h00);
    check("reset_health", {7'd0, health_fail}, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Reset mid-collection with five bits held.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    for (int i = 0; i < 3; i++) drive_ro(1'b0, 1'b0);
    @(negedge clock);
    check("partial_data", word_data, 8'h1B);
    check("partial_valid", {7'd0, word_valid}, 8'h00);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_valid", {7'd0, word_valid}, 8'h00);
    check("midreset_data", word_data, 8'h00);
    check("midreset_health", {7'd0, health_fail}, 8'h00);
    reset  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clock);

    // Basic word assembly straight from the raw stream.
`ifdef RO_VON_NEUMANN_EN
    raw20 = 20'b10_01_11_10_00_01_10_10_01_01;
    for (int i = 19; i >= 0; i--) send_raw(raw20[i]);
    flush();
    check("vn_word_valid", {7'd0, word_valid}, 8'h01);
    check("vn_word_data", word_data, 8'hAC);
`else
    raw8 = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) send_raw(raw8[i]);
    flush();
    check("raw_word_valid", {7'd0, word_valid}, 8'h01);
    check("raw_word_data", word_data, 8'hB2);
`endif
    @(negedge clock);
    check("word_one_cycle", {7'd0, word_valid}, 8'h00);

    // Backpressure: the held word stays put while extra bits are dropped,
    // and survives enable going low.
    word_ready = 1'b0;
    send_word(8'h5C);
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    check("stall_valid", {7'd0, word_valid}, 8'h01);
    check("stall_data_mid", word_data, 8'h5C);
    for (int i = 0; i < 10; i++) send_bit(~i[0]);
    check("stall_data_end", word_data, 8'h5C);
    flush();
    repeat (2) @(negedge clock);
    check("pending_valid", {7'd0, word_valid}, 8'h01);
    check("pending_data", word_data, 8'h5C);
    word_ready = 1'b1;
    @(negedge clock);
    check("pending_xfer", {7'd0, word_valid}, 8'h00);
    send_word(8'hE1);
    flush();
    check("next_valid", {7'd0, word_valid}, 8'h01);
    check("next_data", word_data, 8'hE1);
    @(negedge clock);

    // A partial word is abandoned when enable drops.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    flush();
    send_word(8'h3A);
    flush();
    check("fresh_valid", {7'd0, word_valid}, 8'h01);
    check("fresh_data", word_data, 8'h3A);
    @(negedge clock);

    // Health boundary: REP_LIMIT-1 identical raw bits must not trip.
    for (int i = 0; i < 15; i++) drive_ro(1'b1, 1'b1);
    send_raw(1'b0);
    flush();
    check("limit_minus1_health", {7'd0, health_fail}, 8'h00);
`ifdef RO_VON_NEUMANN_EN
    check("limit_minus1_valid", {7'd0, word_valid}, 8'h00);
    check("limit_minus1_data", word_data, 8'h75);
    frozen = 8'h75;
`else
    check("limit_minus1_valid", {7'd0, word_valid}, 8'h01);
    check("limit_minus1_data", word_data, 8'hFE);
    frozen = 8'hFF;
`endif
    @(negedge clock);

    // REP_LIMIT identical raw bits trip the sticky flag.
    for (int i = 0; i < 16; i++) drive_ro(1'b1, 1'b1);
    flush();
    check("trip_health", {7'd0, health_fail}, 8'h01);
    check("trip_valid", {7'd0, word_valid}, 8'h00);
    for (int i = 0; i < 10; i++) send_raw(i[0]);
    @(negedge clock);
    check("sticky_health", {7'd0, health_fail}, 8'h01);
    check("sticky_valid", {7'd0, word_valid}, 8'h00);
    check("sticky_data", word_data, frozen);
    reset = 1'b1;
    @(negedge clock);
    check("clear_health", {7'd0, health_fail}, 8'h00);
    check("clear_data", word_data, 8'h00);
    reset  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clock);

    // Collection resumes normally after reset.
    send_word(8'hC3);
    flush();
    check("recover_valid", {7'd0, word_valid}, 8'h01);
    check("recover_data", word_data, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
